dec_control: RTL

Fixed-schedule sequencer for the decoder half of the 20-bit Level-3 VAE datapath. It waits for the encoder sequencer's completion flag, then releases the three decoder layer stages (dec1, dec2, dec3) from hold in order, one per programmed cycle budget. When the final sigmoid stage has settled, it raises a sticky done flag and a one-cycle pulse. It sits beside the encoder sequencer at the top level and drives the hold inputs of the decoder layer blocks.

---
 rtl/dec_control.sv | 108 ++++++++++
 1 files changed

// File: rtl/dec_control.sv
// Decoder-side sequencer: after the encoder finishes, releases dec1..dec3 from
// hold on a fixed cycle schedule, then raises a sticky done flag and a pulse.
module dec_control #(
  parameter int OFFSET    = 2,
  parameter int DEC1_CC   = 8,
  parameter int SOFTPLUS1 = 3,
  parameter int DEC2_CC   = 8,
  parameter int SOFTPLUS2 = 3,
  parameter int DEC3_CC   = 12,
  parameter int SIGMOID   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart_i,
  input  logic       enc_done_i,
  output logic       dec1_hold_o,
  output logic       dec2_hold_o,
  output logic       dec3_hold_o,
  output logic       busy_o,
  output logic       done_flag_o,
  output logic       done_pulse_o,
  output logic [6:0] debug_cc_o,
  output logic [1:0] debug_state_o
);

  // Release points in run cycles; T3 must stay below 127 so cc never wraps.
  localparam logic [6:0] T0 = 7'(OFFSET);
  localparam logic [6:0] T1 = 7'(OFFSET + DEC1_CC + SOFTPLUS1);
  localparam logic [6:0] T2 = 7'(OFFSET + DEC1_CC + SOFTPLUS1 + DEC2_CC + SOFTPLUS2);
  localparam logic [6:0] T3 = 7'(OFFSET + DEC1_CC + SOFTPLUS1 + DEC2_CC + SOFTPLUS2
                                 + DEC3_CC + SIGMOID);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q;
  logic [6:0] cc_q;
  logic       dec1_hold_q;
  logic       dec2_hold_q;
  logic       dec3_hold_q;
  logic       done_flag_q;
  logic       done_pulse_q;
  logic       enc_done_q;
  logic       start;

  assign start = enc_done_i & ~enc_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cc_q         <= 7'd0;
      dec1_hold_q  <= 1'b1;
      dec2_hold_q  <= 1'b1;
      dec3_hold_q  <= 1'b1;
      done_flag_q  <= 1'b0;
      done_pulse_q <= 1'b0;
      enc_done_q   <= 1'b0;
    end else if (restart_i) begin
      // Sampling enc_done here means a level still high cannot retrigger.
      state_q      <= IDLE;
      cc_q         <= 7'd0;
      dec1_hold_q  <= 1'b1;
      dec2_hold_q  <= 1'b1;
      dec3_hold_q  <= 1'b1;
      done_flag_q  <= 1'b0;
      done_pulse_q <= 1'b0;
      enc_done_q   <= enc_done_i;
    end else begin
      enc_done_q   <= enc_done_i;
      done_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cc_q    <= 7'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          cc_q <= cc_q + 7'd1;
          if (cc_q == T0) dec1_hold_q <= 1'b0;
          if (cc_q == T1) dec2_hold_q <= 1'b0;
          if (cc_q == T2) dec3_hold_q <= 1'b0;
          if (cc_q == T3) begin
            done_flag_q  <= 1'b1;
            done_pulse_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec1_hold_o   = dec1_hold_q;
  assign dec2_hold_o   = dec2_hold_q;
  assign dec3_hold_o   = dec3_hold_q;
  assign done_flag_o   = done_flag_q;
  assign done_pulse_o  = done_pulse_q;
  assign debug_cc_o    = cc_q;
  assign busy_o        = (state_q == RUN);
  assign debug_state_o = state_q;

endmodule
